tetris_sequencer: RTL and testbench
===================================

TETRIS_SEQUENCER -- requirements
Module: tetris_sequencer

Interface
REQ-001 SHALL have parameter ROWS, default 23, board height in rows.
REQ-002 SHALL have parameter REPEAT_DELAY, default 12, frames a key is held before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_RATE, default 4, frames between auto-repeat moves.
REQ-004 SHALL have port clock_framerate  in  1  frame clock; all logic on its rising edge.
REQ-005 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-006 SHALL have ports start_game, key_left, key_right  in  1 each  level inputs, already synchronised.
REQ-007 SHALL have port fall_tick  in  1  one-cycle gravity pulse.
REQ-008 SHALL have ports filled_under, filled_left, filled_right, spawn_blocked, row_full  in  1 each  datapath collision and row status.
REQ-009 SHALL have ports clear_board, load_block, move_down, move_left, move_right, lock_piece, clear_row  out  1 each  one-cycle datapath commands.
REQ-010 SHALL have ports row_sel  out  5  row under scan or clear; lines  out  16  total lines cleared; game_over  out  1  level.

Function
REQ-011 SHALL implement states IDLE, SPAWN, FALL, LOCK, SCAN, CLEAR, OVER.
REQ-012 IDLE SHALL, on start_game=1, pulse clear_board and go to SPAWN; lines SHALL clear to 0 on the same edge.
REQ-013 SPAWN SHALL pulse load_block for one cycle; on the next cycle, if spawn_blocked=1 go to OVER, else go to FALL.
REQ-014 In FALL, on fall_tick with filled_under=0, SHALL pulse move_down; on fall_tick with filled_under=1, SHALL go to LOCK.
REQ-015 In FALL, a left request with filled_left=0 SHALL pulse move_left; a right request with filled_right=0 SHALL pulse move_right.
REQ-016 At most one move_* pulse SHALL occur per cycle, with priority fall_tick > left > right; a key request blocked by fall_tick SHALL be held pending and issued on the next cycle.
REQ-017 Key requests made while filled_left=1 or filled_right=1 (as applicable) SHALL be dropped, not queued.
REQ-018 LOCK SHALL pulse lock_piece for one cycle, set row_sel=0, and go to SCAN.
REQ-019 In SCAN with row_full=1, SHALL go to CLEAR; with row_full=0 and row_sel<ROWS-1, SHALL increment row_sel; with row_full=0 and row_sel=ROWS-1, SHALL go to SPAWN.
REQ-020 CLEAR SHALL pulse clear_row for one cycle with row_sel unchanged, increment lines (saturating at 16'hFFFF), and return to SCAN to rescan the same row.
REQ-021 OVER SHALL hold game_over=1 and issue no commands; on start_game=1 it SHALL behave as IDLE (REQ-012).
REQ-022 Keys and fall_tick SHALL be ignored in every state except FALL; the pending key (REQ-016) SHALL be discarded on leaving FALL.

Reset
REQ-023 While resetn=0 at a clock edge: state=IDLE, all command outputs=0, row_sel=0, lines=0, game_over=0, and the pending key and repeat counters cleared.
REQ-024 Reset asserted mid-SCAN or mid-CLEAR SHALL abort the operation with no further clear_row pulse.

Configuration
REQ-025 With macro TETRIS_KEY_REPEAT_EN defined, a held key SHALL produce one request on its rising edge, then another after REPEAT_DELAY frames, then one every REPEAT_RATE frames until released.
REQ-026 Without TETRIS_KEY_REPEAT_EN, each key SHALL produce exactly one request per 0->1 transition, and REPEAT_DELAY and REPEAT_RATE SHALL be unused.

Structure
REQ-027 The state enum, ROWS default and board width constant (10) SHALL be placed in shared package tetris_pkg.
REQ-028 Edge detection and auto-repeat SHALL be in sub-module key_repeat, instantiated once per key.

Verification
REQ-029 Reset then start_game=1 -> clear_board and load_block pulse on consecutive cycles; spawn_blocked=0 -> state FALL, lines=0.
REQ-030 In FALL, fall_tick and key_left rising on the same cycle with filled_under=0, filled_left=0 -> move_down in cycle N, move_left in cycle N+1.
REQ-031 fall_tick with filled_under=1 -> lock_piece, then row_sel scans 0..22; row_full=1 at rows 3 and 4 -> two clear_row pulses, both at row_sel=3, lines=2, then load_block.
REQ-032 spawn_blocked=1 after load_block -> game_over=1; start_game=1 -> clear_board, game_over=0, lines=0.
REQ-033 With TETRIS_KEY_REPEAT_EN defined, key_right held 24 frames (filled_right=0) -> move_right in frames 0, 12, 16, 20; without the macro -> move_right in frame 0 only.
REQ-034 resetn=0 during CLEAR -> next cycle state IDLE, no clear_row pulse, lines=0.

Source files
------------

// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_pkg
//  Description : Shared types and constants for the Tetris game sequencer:
//                sequencer state encoding, board geometry and a saturating
//                line-counter helper.
//  Revision    : 1.0  initial release
// ============================================================================
package tetris_pkg;

  localparam int ROWS_DEFAULT = 23;  // board height in rows
  localparam int BOARD_WIDTH  = 10;  // board width in columns
  localparam int ROW_SEL_W    = 5;   // enough to address ROWS_DEFAULT rows
  localparam int LINES_W      = 16;  // cleared-line counter width

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SPAWN = 3'd1,
    FALL  = 3'd2,
    LOCK  = 3'd3,
    SCAN  = 3'd4,
    CLEAR = 3'd5,
    OVER  = 3'd6
  } state_t;

  // Line counter increments stop at all-ones instead of wrapping to zero.
  function automatic logic [LINES_W-1:0] lines_sat_inc(input logic [LINES_W-1:0] v);
    return (v == {LINES_W{1'b1}}) ? v : v + {{(LINES_W-1){1'b0}}, 1'b1};
  endfunction

endpackage : tetris_pkg
`default_nettype wire

// File: rtl/tetris_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_sequencer_if
//  Description : Command/status bundle between the game sequencer (master)
//                and the board datapath (slave). Status flows to the
//                sequencer, one-cycle commands and score/row info flow out.
//  Revision    : 1.0  initial release
// ============================================================================
interface tetris_sequencer_if;

  // datapath status
  logic        filled_under;
  logic        filled_left;
  logic        filled_right;
  logic        spawn_blocked;
  logic        row_full;

  // sequencer commands and state
  logic        clear_board;
  logic        load_block;
  logic        move_down;
  logic        move_left;
  logic        move_right;
  logic        lock_piece;
  logic        clear_row;
  logic [4:0]  row_sel;
  logic [15:0] lines;
  logic        game_over;

  modport master (
    input  filled_under, filled_left, filled_right, spawn_blocked, row_full,
    output clear_board, load_block, move_down, move_left, move_right,
           lock_piece, clear_row, row_sel, lines, game_over
  );

  modport slave (
    output filled_under, filled_left, filled_right, spawn_blocked, row_full,
    input  clear_board, load_block, move_down, move_left, move_right,
           lock_piece, clear_row, row_sel, lines, game_over
  );

endinterface : tetris_sequencer_if
`default_nettype wire

// File: rtl/key_repeat.sv
`default_nettype none
// ============================================================================
//  Module      : key_repeat
//  Description : Turns a synchronised key level into one-cycle move
//                requests. Always fires on the 0->1 edge. With macro
//                TETRIS_KEY_REPEAT_EN defined, a held key fires again
//                REPEAT_DELAY frames after the edge and then every
//                REPEAT_RATE frames until released.
//  Revision    : 1.0  initial release
// ============================================================================
module key_repeat #(
  parameter int REPEAT_DELAY = 12,
  parameter int REPEAT_RATE  = 4
) (
  input  wire logic clock_framerate,
  input  wire logic resetn,
  input  wire logic key,
  output logic      req
);

  logic r_prev;
  logic w_rise;

  assign w_rise = key & ~r_prev;

  // Previous key level for edge detection.
  always_ff @(posedge clock_framerate) begin
    if (!resetn) r_prev <= 1'b0;
    else         r_prev <= key;
  end

`ifdef TETRIS_KEY_REPEAT_EN
  // Frames remaining until the next repeat; zero while held means fire now.
  logic [15:0] r_cnt;
  logic        w_repeat;

  assign w_repeat = key & r_prev & (r_cnt == 16'd0);
  assign req      = w_rise | w_repeat;

  // Load the initial delay on the press, then reload the repeat period on each repeat.
  always_ff @(posedge clock_framerate) begin
    if (!resetn) begin
      r_cnt <= 16'd0;
    end else if (w_rise) begin
      r_cnt <= 16'(REPEAT_DELAY - 1);
    end else if (key) begin
      if (r_cnt == 16'd0) r_cnt <= 16'(REPEAT_RATE - 1);
      else                r_cnt <= r_cnt - 16'd1;
    end else begin
      r_cnt <= 16'd0;
    end
  end
`else
  assign req = w_rise;
`endif

endmodule : key_repeat
`default_nettype wire

// File: rtl/tetris_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tetris_sequencer
//  Description : Game-flow controller for a Tetris board datapath. Spawns
//                pieces, applies gravity and player moves, locks pieces,
//                scans and clears full rows and counts cleared lines.
//                All commands are registered one-cycle pulses that are
//                visible during the state that owns them.
//                Optional feature: define TETRIS_KEY_REPEAT_EN to enable
//                key auto-repeat in the key_repeat instances.
//  Revision    : 1.0  initial release
// ============================================================================
import tetris_pkg::*;

module tetris_sequencer #(
  parameter int ROWS         = ROWS_DEFAULT,
  parameter int REPEAT_DELAY = 12,
  parameter int REPEAT_RATE  = 4
) (
  input  wire logic            clock_framerate,
  input  wire logic            resetn,
  input  wire logic            start_game,
  input  wire logic            key_left,
  input  wire logic            key_right,
  input  wire logic            fall_tick,
  tetris_sequencer_if.master   dp
);

  // Index 0 = left key, index 1 = right key.
  logic [1:0] w_keys;
  logic [1:0] w_key_req;

  assign w_keys = {key_right, key_left};

  generate
    for (genvar i = 0; i < 2; i++) begin : g_key
      key_repeat #(
        .REPEAT_DELAY (REPEAT_DELAY),
        .REPEAT_RATE  (REPEAT_RATE)
      ) u_key_repeat (
        .clock_framerate (clock_framerate),
        .resetn          (resetn),
        .key             (w_keys[i]),
        .req             (w_key_req[i])
      );
    end
  endgenerate

  state_t              r_state;
  logic [1:0]          r_spawn_phase;
  logic                r_pend_left;
  logic                r_pend_right;
  logic                r_clear_board;
  logic                r_load_block;
  logic                r_move_down;
  logic                r_move_left;
  logic                r_move_right;
  logic                r_lock_piece;
  logic                r_clear_row;
  logic [ROW_SEL_W-1:0] r_row_sel;
  logic [LINES_W-1:0]  r_lines;
  logic                r_game_over;

  // A move is issued only into free space, so a blocked key (new or pending) is dropped.
  logic w_left_go;
  logic w_right_go;

  assign w_left_go  = (w_key_req[0] | r_pend_left)  & ~dp.filled_left;
  assign w_right_go = (w_key_req[1] | r_pend_right) & ~dp.filled_right;

  // Main game FSM; every command defaults low so it pulses for one cycle.
  always_ff @(posedge clock_framerate) begin
    if (!resetn) begin
      r_state       <= IDLE;
      r_spawn_phase <= 2'd0;
      r_pend_left   <= 1'b0;
      r_pend_right  <= 1'b0;
      r_clear_board <= 1'b0;
      r_load_block  <= 1'b0;
      r_move_down   <= 1'b0;
      r_move_left   <= 1'b0;
      r_move_right  <= 1'b0;
      r_lock_piece  <= 1'b0;
      r_clear_row   <= 1'b0;
      r_row_sel     <= '0;
      r_lines       <= '0;
      r_game_over   <= 1'b0;
    end else begin
      r_clear_board <= 1'b0;
      r_load_block  <= 1'b0;
      r_move_down   <= 1'b0;
      r_move_left   <= 1'b0;
      r_move_right  <= 1'b0;
      r_lock_piece  <= 1'b0;
      r_clear_row   <= 1'b0;
      r_pend_left   <= 1'b0;
      r_pend_right  <= 1'b0;

      case (r_state)
        IDLE, OVER: begin
          if (start_game) begin
            r_clear_board <= 1'b1;
            r_lines       <= '0;
            r_game_over   <= 1'b0;
            r_spawn_phase <= 2'd0;
            r_state       <= SPAWN;
          end
        end

        // Phase 0 issues load_block, phase 1 is the load cycle itself,
        // phase 2 sees the post-load collision status.
        SPAWN: begin
          case (r_spawn_phase)
            2'd0: begin
              r_load_block  <= 1'b1;
              r_spawn_phase <= 2'd1;
            end
            2'd1: begin
              r_spawn_phase <= 2'd2;
            end
            default: begin
              r_spawn_phase <= 2'd0;
              if (dp.spawn_blocked) begin
                r_game_over <= 1'b1;
                r_state     <= OVER;
              end else begin
                r_state     <= FALL;
              end
            end
          endcase
        end

        // Gravity wins over keys; a key that loses to gravity or to the
        // other key is kept pending for the following cycle.
        FALL: begin
          if (fall_tick) begin
            if (dp.filled_under) begin
              r_lock_piece <= 1'b1;
              r_row_sel    <= '0;
              r_state      <= LOCK;
            end else begin
              r_move_down  <= 1'b1;
              r_pend_left  <= w_left_go;
              r_pend_right <= w_right_go;
            end
          end else if (w_left_go) begin
            r_move_left  <= 1'b1;
            r_pend_right <= w_right_go;
          end else if (w_right_go) begin
            r_move_right <= 1'b1;
          end
        end

        LOCK: begin
          r_state <= SCAN;
        end

        SCAN: begin
          if (dp.row_full) begin
            r_clear_row <= 1'b1;
            r_lines     <= lines_sat_inc(r_lines);
            r_state     <= CLEAR;
          end else if (r_row_sel < ROW_SEL_W'(ROWS - 1)) begin
            r_row_sel   <= r_row_sel + 1'b1;
          end else begin
            r_spawn_phase <= 2'd0;
            r_state       <= SPAWN;
          end
        end

        // Rows above collapse into row_sel, so the same row is rescanned.
        CLEAR: begin
          r_state <= SCAN;
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign dp.clear_board = r_clear_board;
  assign dp.load_block  = r_load_block;
  assign dp.move_down   = r_move_down;
  assign dp.move_left   = r_move_left;
  assign dp.move_right  = r_move_right;
  assign dp.lock_piece  = r_lock_piece;
  assign dp.clear_row   = r_clear_row;
  assign dp.row_sel     = r_row_sel;
  assign dp.lines       = r_lines;
  assign dp.game_over   = r_game_over;

endmodule : tetris_sequencer
`default_nettype wire

// File: tb/tb_tetris_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tetris_sequencer
//  Description : Directed self-checking bench for tetris_sequencer with a
//                command scoreboard and a tiny row-full board model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tetris_sequencer;
  import tetris_pkg::*;

  localparam logic [6:0] C_CLEAR_BOARD = 7'b1000000;
  localparam logic [6:0] C_LOAD        = 7'b0100000;
  localparam logic [6:0] C_DOWN        = 7'b0010000;
  localparam logic [6:0] C_LEFT        = 7'b0001000;
  localparam logic [6:0] C_RIGHT       = 7'b0000100;
  localparam logic [6:0] C_LOCK        = 7'b0000010;
  localparam logic [6:0] C_CLR_ROW     = 7'b0000001;

  typedef struct packed {
    logic [6:0] cmds;
    logic [4:0] row;
  } ev_t;

  logic clk;
  logic resetn;
  logic start_game;
  logic key_left;
  logic key_right;
  logic fall_tick;
  int   full_cnt;
  int   total;
  int   passed;
  int   failed;
  logic mon_en;
  ev_t  exp_q[$];

  tetris_sequencer_if dif ();

  tetris_sequencer dut (
    .clock_framerate (clk),
    .resetn          (resetn),
    .start_game      (start_game),
    .key_left        (key_left),
    .key_right       (key_right),
    .fall_tick       (fall_tick),
    .dp              (dif.master)
  );

  // Board model: row 3 stays full while full_cnt rows are left to clear.
  assign dif.row_full = (dif.row_sel == 5'd3) && (full_cnt > 0);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] cmd_vec;
  assign cmd_vec = {dif.clear_board, dif.load_block, dif.move_down, dif.move_left,
                    dif.move_right, dif.lock_piece, dif.clear_row};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [6:0] cmds, input logic [4:0] row);
    ev_t e;
    e.cmds = cmds;
    e.row  = row;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every command pulse must match the next expected event.
  always @(negedge clk) begin
    if (mon_en && cmd_vec != 7'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_cmd", 32'(cmd_vec), 32'd0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("cmd_order", 32'(cmd_vec), 32'(e.cmds));
        if (e.cmds == C_CLR_ROW) check("clear_row_sel", 32'(dif.row_sel), 32'(e.row));
      end
    end
  end

  initial begin
    logic [4:0] rows_seen[$];
    int         clr_cnt;
    int         ordered;
    bit         found;
    bit         rep_en;

    total = 0; passed = 0; failed = 0; full_cnt = 0; mon_en = 1'b0;
    resetn = 1'b0; start_game = 1'b0; key_left = 1'b0; key_right = 1'b0; fall_tick = 1'b0;
    dif.filled_under = 1'b0; dif.filled_left = 1'b0; dif.filled_right = 1'b0;
    dif.spawn_blocked = 1'b0;
`ifdef TETRIS_KEY_REPEAT_EN
    rep_en = 1'b1;
`else
    rep_en = 1'b0;
`endif

    // Reset state
    repeat (3) step();
    mon_en = 1'b1;
    check("rst_cmds",      32'(cmd_vec),       32'd0);
    check("rst_row_sel",   32'(dif.row_sel),   32'd0);
    check("rst_lines",     32'(dif.lines),     32'd0);
    check("rst_game_over", 32'(dif.game_over), 32'd0);
    check("rst_state",     32'(dut.r_state),   32'(IDLE));
    resetn = 1'b1;
    step();

    // Start: clear_board then load_block, then FALL
    push(C_CLEAR_BOARD, 5'd0);
    push(C_LOAD, 5'd0);
    start_game = 1'b1;
    step();
    check("start_clear_board", 32'(dif.clear_board), 32'd1);
    start_game = 1'b0;
    step();
    check("spawn_load_block", 32'(dif.load_block), 32'd1);
    check("spawn_no_clear",   32'(dif.clear_board), 32'd0);
    step();
    step();
    check("spawn_to_fall", 32'(dut.r_state), 32'(FALL));
    check("start_lines",   32'(dif.lines),   32'd0);

    // Gravity and left key on the same cycle: down first, left next
    push(C_DOWN, 5'd0);
    push(C_LEFT, 5'd0);
    fall_tick = 1'b1; key_left = 1'b1;
    step();
    check("tie_move_down", 32'(dif.move_down), 32'd1);
    check("tie_no_left",   32'(dif.move_left), 32'd0);
    fall_tick = 1'b0;
    step();
    check("pend_move_left", 32'(dif.move_left), 32'd1);
    check("pend_no_down",   32'(dif.move_down), 32'd0);
    key_left = 1'b0;
    step();
    check("left_single", 32'(dif.move_left), 32'd0);

    // Blocked left press is dropped, not queued
    dif.filled_left = 1'b1; key_left = 1'b1;
    step();
    check("blocked_left", 32'(dif.move_left), 32'd0);
    dif.filled_left = 1'b0;
    step();
    check("dropped_left", 32'(dif.move_left), 32'd0);
    key_left = 1'b0;
    step();

    // Right key held 24 frames
    key_right = 1'b1;
    for (int f = 0; f < 24; f++) begin
      bit want;
      want = (f == 0) || (rep_en && (f == 12 || f == 16 || f == 20));
      if (want) push(C_RIGHT, 5'd0);
      step();
      check($sformatf("hold_right_f%0d", f), 32'(dif.move_right), 32'(want));
    end
    key_right = 1'b0;
    step();

    // Lock and scan with rows 3 and 4 full
    push(C_LOCK, 5'd0);
    push(C_CLR_ROW, 5'd3);
    push(C_CLR_ROW, 5'd3);
    push(C_LOAD, 5'd0);
    full_cnt = 2;
    dif.filled_under = 1'b1; fall_tick = 1'b1;
    step();
    check("lock_pulse",   32'(dif.lock_piece), 32'd1);
    check("lock_row_sel", 32'(dif.row_sel),    32'd0);
    dif.filled_under = 1'b0; fall_tick = 1'b0;
    rows_seen.push_back(dif.row_sel);
    clr_cnt = 0;
    found   = 1'b0;
    for (int n = 0; n < 80 && !found; n++) begin
      step();
      if (dif.load_block) found = 1'b1;
      else begin
        if (dif.row_sel != rows_seen[$]) rows_seen.push_back(dif.row_sel);
        if (dif.clear_row) begin
          clr_cnt++;
          full_cnt--;
        end
      end
    end
    check("scan_load_seen", 32'(found), 32'd1);
    ordered = 0;
    foreach (rows_seen[i]) if (rows_seen[i] == 5'(i)) ordered++;
    check("scan_rows_in_order", 32'(ordered), 32'd23);
    check("scan_rows_count",    32'(rows_seen.size()), 32'd23);
    check("clear_row_count",    32'(clr_cnt), 32'd2);
    check("lines_after_clear",  32'(dif.lines), 32'd2);

    // Spawn blocked: game over, commands ignored, restart
    dif.spawn_blocked = 1'b1;
    step();
    step();
    check("game_over_set", 32'(dif.game_over), 32'd1);
    fall_tick = 1'b1; key_left = 1'b1;
    step();
    check("over_quiet_0", 32'(cmd_vec), 32'd0);
    key_left = 1'b0;
    step();
    check("over_quiet_1", 32'(cmd_vec), 32'd0);
    check("over_hold",    32'(dif.game_over), 32'd1);
    fall_tick = 1'b0;
    push(C_CLEAR_BOARD, 5'd0);
    push(C_LOAD, 5'd0);
    start_game = 1'b1;
    step();
    check("restart_clear_board", 32'(dif.clear_board), 32'd1);
    check("restart_game_over",   32'(dif.game_over),   32'd0);
    check("restart_lines",       32'(dif.lines),       32'd0);
    start_game = 1'b0; dif.spawn_blocked = 1'b0;
    step();
    step();
    step();
    check("restart_fall", 32'(dut.r_state), 32'(FALL));

    // Reset during CLEAR aborts the clear
    push(C_LOCK, 5'd0);
    push(C_CLR_ROW, 5'd3);
    full_cnt = 1;
    dif.filled_under = 1'b1; fall_tick = 1'b1;
    step();
    dif.filled_under = 1'b0; fall_tick = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      step();
      if (dif.clear_row) found = 1'b1;
    end
    check("clear_reached", 32'(found), 32'd1);
    check("clear_lines",   32'(dif.lines), 32'd1);
    resetn = 1'b0; full_cnt = 0;
    step();
    check("abort_state",     32'(dut.r_state),   32'(IDLE));
    check("abort_clear_row", 32'(dif.clear_row), 32'd0);
    check("abort_lines",     32'(dif.lines),     32'd0);
    resetn = 1'b1;
    step();
    check("abort_quiet", 32'(cmd_vec), 32'd0);
    step();

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_tetris_sequencer
`default_nettype wire
